// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;
  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, owner, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, owner, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters (IDLE/ISSUE/WAIT/RESP).
// Define MEM_ARB_PERF_EN to add the conflict_cnt / starve_hit_cnt performance counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       starve_hit_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              owner_q, owner_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;

  logic any_req;
  logic starve_ok;
  logic grant_dm;

  assign any_req   = bus.if_req | bus.dm_req;
  assign starve_ok = (starve_cnt_q < STARVE_LIM);
  // Data wins unless fetch has been starved; a lone data request still wins at the limit.
  assign grant_dm  = (bus.dm_req & starve_ok) | ~bus.if_req;

  always_comb begin
    state_d      = state_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_valid_d   = 1'b0;
    dm_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d     = grant_dm;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_dm & bus.dm_we;
          mem_addr_d  = grant_dm ? bus.dm_addr : bus.if_addr;
          mem_wdata_d = grant_dm ? bus.dm_wdata : mem_wdata_q;
          if (!grant_dm) begin
            starve_cnt_d = 4'd0;
          end else if (bus.if_req && starve_ok) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          if_valid_d = ~owner_q;
          dm_valid_d = owner_q;
          state_d    = RESP;
        end else begin
          lat_cnt_d = LAT_INIT;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          if (owner_q) begin
            dm_rdata_d = bus.mem_rdata;
          end else begin
            if_rdata_d = bus.mem_rdata;
          end
          if_valid_d = ~owner_q;
          dm_valid_d = owner_q;
          state_d    = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      owner_q      <= 1'b0;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_valid_q   <= if_valid_d;
      dm_valid_q   <= dm_valid_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic [15:0] starve_hit_cnt_q, starve_hit_cnt_d;

  always_comb begin
    conflict_cnt_d   = conflict_cnt_q;
    starve_hit_cnt_d = starve_hit_cnt_q;
    if (state_q == IDLE) begin
      if (bus.if_req && bus.dm_req && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
      // Forced means data was requesting and would otherwise have won.
      if (bus.if_req && bus.dm_req && !starve_ok && (starve_hit_cnt_q != 16'hFFFF)) begin
        starve_hit_cnt_d = starve_hit_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflict_cnt_q   <= 16'd0;
      starve_hit_cnt_q <= 16'd0;
    end else begin
      conflict_cnt_q   <= conflict_cnt_d;
      starve_hit_cnt_q <= starve_hit_cnt_d;
    end
  end

  assign conflict_cnt   = conflict_cnt_q;
  assign starve_hit_cnt = starve_hit_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: lone fetch/write, contention, starvation, mid-access reset.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_pass;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [15:0] conflict_cnt;
  logic [15:0] starve_hit_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
`ifdef MEM_ARB_PERF_EN
    ,
    .conflict_cnt(conflict_cnt),
    .starve_hit_cnt(starve_hit_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: word array plus a MEM_LAT-deep read pipe, junk when no read is in flight.
  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] rd_pipe [MEM_LAT];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | i;
    mem[4] <= 32'h8C01_0000;
  end

  always @(posedge clock) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 32'h0BAD_0BAD;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_mem_en"},    32'(bus.mem_en), 0);
    chk({tag, "_mem_we"},    32'(bus.mem_we), 0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr), 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_if_valid"},  32'(bus.if_valid), 0);
    chk({tag, "_dm_valid"},  32'(bus.dm_valid), 0);
    chk({tag, "_if_rdata"},  bus.if_rdata, 0);
    chk({tag, "_dm_rdata"},  bus.dm_rdata, 0);
    chk({tag, "_owner"},     32'(bus.owner), 0);
    chk({tag, "_busy"},      32'(bus.busy), 0);
`ifdef MEM_ARB_PERF_EN
    chk({tag, "_conflict"},  32'(conflict_cnt), 0);
    chk({tag, "_starve_hit"}, 32'(starve_hit_cnt), 0);
`endif
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_outputs_zero(tag);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Called at the drive point of the request cycle; returns at the negedge of the valid cycle.
  task automatic wait_valid(input string tag, input logic is_dm, input int exp_cyc);
    int   cyc;
    logic hit;
    logic other;
    cyc = 0; hit = 1'b0; other = 1'b0;
    while (!hit && cyc < 20) begin
      @(negedge clock);
      if (is_dm ? bus.if_valid : bus.dm_valid) other = 1'b1;
      if (is_dm ? bus.dm_valid : bus.if_valid) hit = 1'b1;
      else begin
        @(posedge clock);
        #1;
        cyc++;
      end
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_other_valid"}, 32'(other), 0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    repeat (2) @(negedge clock);
    chk_outputs_zero("rst");
    chk("rst_if_stall", 32'(bus.if_stall), 0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Lone fetch read
    bus.if_req = 1'b1; bus.if_addr = 10'h004;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clock);
      chk($sformatf("t1_mem_en_c%0d", c),   32'(bus.mem_en), 32'(c == 1));
      chk($sformatf("t1_if_valid_c%0d", c), 32'(bus.if_valid), 32'(c == 4));
      chk($sformatf("t1_if_stall_c%0d", c), 32'(bus.if_stall), 32'(c != 4));
      chk($sformatf("t1_busy_c%0d", c),     32'(bus.busy), 32'(c != 0));
      if (c == 1) begin
        chk("t1_mem_addr", 32'(bus.mem_addr), 32'h004);
        chk("t1_mem_we",   32'(bus.mem_we), 0);
      end
      if (c < 4) begin
        @(posedge clock);
        #1;
      end
    end
    chk("t1_if_rdata", bus.if_rdata, 32'h8C01_0000);
    chk("t1_owner", 32'(bus.owner), 0);
    chk("t1_dm_valid", 32'(bus.dm_valid), 0);
    @(posedge clock);
    #1;
    bus.if_req = 1'b0;

    // Lone data write
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'h010; bus.dm_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clock);
      chk($sformatf("t2_mem_en_c%0d", c),   32'(bus.mem_en), 32'(c == 1));
      chk($sformatf("t2_dm_valid_c%0d", c), 32'(bus.dm_valid), 32'(c == 2));
      chk($sformatf("t2_dm_stall_c%0d", c), 32'(bus.dm_stall), 32'(c != 2));
      if (c == 1) begin
        chk("t2_mem_we",    32'(bus.mem_we), 1);
        chk("t2_mem_addr",  32'(bus.mem_addr), 32'h010);
        chk("t2_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      end
      if (c < 2) begin
        @(posedge clock);
        #1;
      end
    end
    chk("t2_dm_rdata_held", bus.dm_rdata, 0);
    chk("t2_owner", 32'(bus.owner), 1);
    @(posedge clock);
    #1;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;

    // Simultaneous requests: data first, then fetch
    bus.if_req = 1'b1; bus.if_addr = 10'h020;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'h010;
    wait_valid("t3_dm", 1'b1, 4);
    chk("t3_dm_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
    chk("t3_owner_dm", 32'(bus.owner), 1);
    chk("t3_starve_1", 32'(dut.starve_cnt_q), 1);
    chk("t3_if_stall", 32'(bus.if_stall), 1);
    @(posedge clock);
    #1;
    bus.dm_req = 1'b0;
    wait_valid("t3_if", 1'b0, 4);
    chk("t3_if_rdata", bus.if_rdata, 32'hA500_0020);
    chk("t3_owner_if", 32'(bus.owner), 0);
    chk("t3_starve_0", 32'(dut.starve_cnt_q), 0);
    @(posedge clock);
    #1;
    bus.if_req = 1'b0;

    // Starvation: data held with back-to-back reads, fetch waiting
    do_reset("t4_rst");
    bus.if_req = 1'b1; bus.if_addr = 10'h030;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.dm_addr = 10'(10'h040 + k);
      wait_valid($sformatf("t4_dm%0d", k), 1'b1, 4);
      chk($sformatf("t4_owner%0d", k), 32'(bus.owner), 1);
      chk($sformatf("t4_dm_rdata%0d", k), bus.dm_rdata, 32'hA500_0040 + k);
      @(posedge clock);
      #1;
    end
    bus.dm_addr = 10'h044;
    wait_valid("t4_if", 1'b0, 4);
    chk("t4_owner_forced", 32'(bus.owner), 0);
    chk("t4_if_rdata", bus.if_rdata, 32'hA500_0030);
    chk("t4_dm_stall", 32'(bus.dm_stall), 1);
`ifdef MEM_ARB_PERF_EN
    chk("t4_conflict_cnt", 32'(conflict_cnt), 5);
    chk("t4_starve_hit_cnt", 32'(starve_hit_cnt), 1);
`endif
    @(posedge clock);
    #1;
    bus.if_req = 1'b0;
    wait_valid("t4_dm_last", 1'b1, 4);
    chk("t4_dm_rdata_last", bus.dm_rdata, 32'hA500_0044);
    @(posedge clock);
    #1;

    // Reset while the data read sits in WAIT
    bus.dm_addr = 10'h050;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    chk("t5_busy_wait", 32'(bus.busy), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_outputs_zero("t5_rst");
    bus.dm_req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      chk($sformatf("t5_no_dm_valid_c%0d", c), 32'(bus.dm_valid), 0);
      chk($sformatf("t5_idle_c%0d", c), 32'(bus.busy), 0);
    end
    @(posedge clock);
    #1;
    bus.if_req = 1'b1; bus.if_addr = 10'h060;
    wait_valid("t5_if", 1'b0, 4);
    chk("t5_if_rdata", bus.if_rdata, 32'hA500_0060);
    chk("t5_dm_rdata", bus.dm_rdata, 0);
    @(posedge clock);
    #1;
    bus.if_req = 1'b0;
    repeat (2) @(posedge clock);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester and the data-memory requester.
- Sequences each access through a fixed issue/wait/response flow.
- Generates the per-requester stall signals that feed the pipeline's existing stall path.
- Data requests normally win; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_W, 10, memory address width (matches the PC width)
DATA_W, 32, data width
MEM_LAT, 2, cycles from the mem_en cycle to mem_rdata valid (legal range 1..15)
STARVE_MAX, 4, consecutive lost arbitrations after which fetch gets forced priority (legal range 1..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
if_req  in  1  fetch request; held high until if_valid
if_addr  in  ADDR_W  fetch address; stable while if_req is high
if_rdata  out  DATA_W  fetch read data; valid when if_valid=1
if_valid  out  1  one-cycle completion pulse for fetch
if_stall  out  1  if_req & ~if_valid (combinational)
dm_req  in  1  data request; held high until dm_valid
dm_we  in  1  1 = write, 0 = read; stable while dm_req is high
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_rdata  out  DATA_W  data read result; valid when dm_valid=1
dm_valid  out  1  one-cycle completion pulse for data
dm_stall  out  1  dm_req & ~dm_valid (combinational)
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
owner  out  1  current or last grant: 0 = fetch, 1 = data
busy  out  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE. The following are 0: mem_en, mem_we, mem_addr, mem_wdata, if_valid, dm_valid, if_rdata, dm_rdata, owner, latency counter, starvation counter. Any in-flight access is abandoned and no valid pulse is ever produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitrates when any request is high.
  - Winner is data if dm_req=1 and starve_cnt < STARVE_MAX; otherwise fetch if if_req=1; otherwise data.
  - Winner's address, write data and write flag are registered into mem_* (a fetch grant forces mem_we=0). owner is set to the winner.
  - Next state is ISSUE.
- ISSUE: mem_en=1 for exactly one cycle.
  - Write: next state RESP.
  - Read: next state WAIT, with lat_cnt loaded to MEM_LAT-1.
- WAIT: lat_cnt decrements each cycle. When lat_cnt=0, mem_rdata is captured into the owner's rdata register and the next state is RESP.
- RESP: the owner's valid pulses high for one cycle. Requests are not sampled in RESP. Next state is IDLE.
- Latency from request seen in IDLE to valid:
  - Read: MEM_LAT+2 cycles (4 at default).
  - Write: 2 cycles.
- rdata registers hold their value until the next capture.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) in each IDLE arbitration where if_req=1 and data wins.
  - Clears when fetch is granted.
  - Unchanged on an arbitration with if_req=0.
- Requesters drop or re-present req in the cycle after their valid pulse. The arbiter is never re-entered mid-transaction.
- If a request drops before its valid pulse (protocol violation), the transaction still completes and the valid pulse is still emitted.
- mem_en is never high in two consecutive cycles.
- Only one valid pulse is produced per transaction.
- if_valid and dm_valid are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds two output ports:
  - conflict_cnt (16 bit): increments in each IDLE cycle with if_req & dm_req both high.
  - starve_hit_cnt (16 bit): increments when a fetch grant is forced by starve_cnt = STARVE_MAX.
- Both counters saturate at 16'hFFFF and reset to 0.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Lone fetch read: if_req=1, if_addr=0x004, mem_rdata=0x8C010000 at MEM_LAT → if_valid pulses on cycle 4 with if_rdata=0x8C010000; if_stall=1 for cycles 0-3; mem_en high only on cycle 1.
- Lone data write: dm_req=1, dm_we=1, addr=0x010, wdata=0xDEADBEEF → mem_en=mem_we=1 on cycle 1 with mem_wdata=0xDEADBEEF; dm_valid on cycle 2; dm_rdata unchanged.
- Simultaneous requests, both held: data wins first; fetch completes in the next transaction; owner sequence is 1 then 0; starve_cnt goes 1 then 0.
- Starvation, STARVE_MAX=4, dm_req held continuously with back-to-back reads and if_req high: four data grants, then the fifth grant goes to fetch (owner=0) even though dm_req=1.
- Reset mid-WAIT: assert reset=0 during WAIT → all outputs 0 immediately; after release, no valid pulse appears for the abandoned access and the next request starts cleanly from IDLE.
- With MEM_ARB_PERF_EN defined: run the starvation scenario above → conflict_cnt=5 and starve_hit_cnt=1.
